// File: rtl/uart_tx_arbiter.sv
// Round-robin owner of a shared UART tx write port: grant, hold i_wr until busy, ack, wait for frame end.
// Latency: request to o_tx_wr 1 cycle; no grant while tx is busy; requesters hold their byte until ack.
module uart_tx_arbiter #(
  parameter int N_REQ       = 2,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [N_REQ-1:0]   i_req,
  input  logic [8*N_REQ-1:0] i_data,
  output logic [N_REQ-1:0]   o_ack,
  output logic [N_REQ-1:0]   o_grant,
  output logic               o_tx_wr,
  output logic [7:0]         o_tx_data,
  input  logic               i_tx_busy,
  output logic               o_timeout
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(ACK_TIMEOUT);
  localparam logic [IW-1:0] LAST_RST = IW'(N_REQ - 1);
  localparam logic [CW-1:0] CNT_END  = CW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     last_q, last_d;
  logic [IW-1:0]     win_q, win_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [N_REQ-1:0]  ack_d, grant_d;
  logic              wr_d, to_d;
  logic [7:0]        dat_d;

  logic              pick_vld;
  logic [IW-1:0]     pick_idx;
  logic [N_REQ-1:0]  pick_oh;
  logic [7:0]        pick_dat;

  // Search indices above last first, then wrap to 0..last: the last served requester ends up lowest.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    pick_oh  = '0;
    pick_dat = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (!pick_vld && i_req[j] && (j > int'(last_q))) begin
        pick_vld   = 1'b1;
        pick_idx   = IW'(j);
        pick_oh[j] = 1'b1;
        pick_dat   = i_data[8*j +: 8];
      end
    end
    for (int j = 0; j < N_REQ; j++) begin
      if (!pick_vld && i_req[j] && (j <= int'(last_q))) begin
        pick_vld   = 1'b1;
        pick_idx   = IW'(j);
        pick_oh[j] = 1'b1;
        pick_dat   = i_data[8*j +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    ack_d   = '0;
    to_d    = 1'b0;
    grant_d = o_grant;
    wr_d    = o_tx_wr;
    dat_d   = o_tx_data;
    case (state_q)
      IDLE: begin
        if (!i_tx_busy && pick_vld) begin
          state_d = ISSUE;
          win_d   = pick_idx;
          grant_d = pick_oh;
          wr_d    = 1'b1;
          dat_d   = pick_dat;
          cnt_d   = '0;
        end
      end
      ISSUE: begin
        if (i_tx_busy) begin
          wr_d    = 1'b0;
          ack_d   = o_grant;
          last_d  = win_q;
          state_d = WAIT_DONE;
        end else if (cnt_q == CNT_END) begin
          // tx never took the byte: release the port without an ack so the requester retries later
          wr_d    = 1'b0;
          to_d    = 1'b1;
          last_d  = win_q;
          grant_d = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!i_tx_busy) begin
          grant_d = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        wr_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      last_q    <= LAST_RST;
      win_q     <= '0;
      cnt_q     <= '0;
      o_ack     <= '0;
      o_grant   <= '0;
      o_tx_wr   <= 1'b0;
      o_tx_data <= '0;
      o_timeout <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      win_q     <= win_d;
      cnt_q     <= cnt_d;
      o_ack     <= ack_d;
      o_grant   <= grant_d;
      o_tx_wr   <= wr_d;
      o_tx_data <= dat_d;
      o_timeout <= to_d;
    end
  end

endmodule
